// File: rtl/tcb_pkg.sv
// Shared TCB arbiter types and the round-robin search helper.
// Sized for the largest supported port count (8 requesters).
package tcb_pkg;

   localparam int unsigned TCB_PN_MAX = 8;
   localparam int unsigned TCB_IW_MAX = 3;

   typedef struct packed {
      logic                  vld;
      logic [TCB_IW_MAX-1:0] idx;
   } tcb_dly_t;

   // First set bit at or after ofs, wrapping at pn; ofs if none set.
   function automatic logic [TCB_IW_MAX-1:0] tcb_rr_idx(
      input logic [TCB_PN_MAX-1:0] req,
      input int unsigned           ofs,
      input int unsigned           pn
   );
      logic [TCB_IW_MAX-1:0] res;
      logic [TCB_IW_MAX-1:0] j;
      res = TCB_IW_MAX'(ofs);
      for (int k = TCB_PN_MAX - 1; k >= 0; k--) begin
         j = TCB_IW_MAX'((ofs + unsigned'(k)) % pn);
         if (k < int'(pn) && req[j]) begin
            res = j;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/tcb_arb_rr_sel.sv
// Combinational round-robin priority selector.
// Searches req starting at ptr, wrapping at PN-1.
module tcb_arb_rr_sel
   import tcb_pkg::*;
#(
   parameter int unsigned PN = 2,
   parameter int unsigned IW = 1
) (
   input  logic [PN-1:0] req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] gnt,
   output logic          any
);

   logic [TCB_PN_MAX-1:0] req_x;

   assign req_x = TCB_PN_MAX'(req);
   assign gnt   = IW'(tcb_rr_idx(req_x, 32'(ptr), PN));
   assign any   = |req;

endmodule

// File: rtl/tcb_arb.sv
// Round-robin arbiter sharing one TCB manager port among PN requesters.
// Responses are steered back through a DLY-deep grant-index delay line.
module tcb_arb
   import tcb_pkg::*;
#(
   parameter  int unsigned AW  = 14,
   parameter  int unsigned DW  = 32,
   parameter  int unsigned PN  = 2,
   parameter  int unsigned DLY = 1,
   localparam int unsigned BW  = DW / 8,
   localparam int unsigned IW  = (PN > 1) ? $clog2(PN) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PN-1:0]    sub_vld,
   input  logic [PN-1:0]    sub_wen,
   input  logic [PN*AW-1:0] sub_adr,
   input  logic [PN*BW-1:0] sub_ben,
   input  logic [PN*DW-1:0] sub_wdt,
   output logic [PN*DW-1:0] sub_rdt,
   output logic [PN-1:0]    sub_err,
   output logic [PN-1:0]    sub_rdy,
   output logic             man_vld,
   output logic             man_wen,
   output logic [AW-1:0]    man_adr,
   output logic [BW-1:0]    man_ben,
   output logic [DW-1:0]    man_wdt,
   input  logic [DW-1:0]    man_rdt,
   input  logic             man_err,
   input  logic             man_rdy,
   output logic [IW-1:0]    gnt
);

   logic [IW-1:0]         ptr;
   logic                  lck;
   logic [IW-1:0]         lgn;
   logic [IW-1:0]         sel_gnt;
   logic                  sel_any;
   logic                  hs;
   logic                  rv;
   logic [TCB_IW_MAX-1:0] ri;

   tcb_arb_rr_sel #(
      .PN (PN),
      .IW (IW)
   ) u_sel (
      .req (sub_vld),
      .ptr (ptr),
      .gnt (sel_gnt),
      .any (sel_any)
   );

   assign gnt     = lck ? lgn : sel_gnt;
   assign man_vld = (lck ? sub_vld[lgn] : sel_any) & ~rst;
   assign hs      = man_vld & man_rdy;

   always_comb begin
      man_wen = 1'b0;
      man_adr = '0;
      man_ben = '0;
      man_wdt = '0;
      sub_rdy = '0;
      for (int i = 0; i < int'(PN); i++) begin
         if (gnt == IW'(i)) begin
            man_wen    = sub_wen[i];
            man_adr    = sub_adr[i*AW +: AW];
            man_ben    = sub_ben[i*BW +: BW];
            man_wdt    = sub_wdt[i*DW +: DW];
            sub_rdy[i] = man_rdy & ~rst;
         end
      end
   end

   // A stalled request keeps its grant until the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
         lck <= 1'b0;
         lgn <= '0;
      end else if (hs) begin
         lck <= 1'b0;
         ptr <= (gnt == IW'(PN - 1)) ? '0 : gnt + IW'(1);
      end else if (man_vld) begin
         lck <= 1'b1;
         lgn <= gnt;
      end
   end

   if (DLY == 0) begin : g_comb
      assign rv = hs;
      assign ri = TCB_IW_MAX'(gnt);
   end else begin : g_pipe
      tcb_dly_t pipe [DLY];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 0; s < int'(DLY); s++) begin
               pipe[s] <= '0;
            end
         end else begin
            pipe[0] <= '{vld: hs, idx: TCB_IW_MAX'(gnt)};
            for (int s = 1; s < int'(DLY); s++) begin
               pipe[s] <= pipe[s-1];
            end
         end
      end

      assign rv = pipe[DLY-1].vld;
      assign ri = pipe[DLY-1].idx;
   end

   always_comb begin
      sub_rdt = '0;
      sub_err = '0;
      for (int i = 0; i < int'(PN); i++) begin
         if (rv && ri == TCB_IW_MAX'(i)) begin
            sub_rdt[i*DW +: DW] = man_rdt;
            sub_err[i]          = man_err;
         end
      end
   end

endmodule
